keycode_event_gen: RTL and testbench

//  Producer side of the keycode interface feeding the game FSM and menus.

---
 rtl/keycode_event_gen.sv | 77 +++++++
 tb/tb_keycode_event_gen.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/keycode_event_gen.sv
// keycode_event_gen: debounces the raw keycode and emits one valid/ready event per press,
// with optional typematic auto-repeat, a debounced held level and a sticky overrun flag.
module keycode_event_gen #(
  parameter logic [15:0] DEBOUNCE_CYC = 16'd1000,
  parameter logic [24:0] REPEAT_DELAY = 25'd25_000_000,
  parameter logic [24:0] REPEAT_RATE  = 25'd5_000_000,
  parameter logic        REPEAT_EN    = 1'b1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] raw_keycode,
  input  logic       key_ready,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_repeat,
  output logic [7:0] held_key,
  output logic       overrun
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DELAY = 2'd1;
  localparam logic [1:0] RPT   = 2'd2;
  logic [7:0]  r_cand;
  logic [15:0] r_cnt;
  logic [7:0]  r_last;
  logic [24:0] r_timer;
  logic [1:0]  r_state;
  logic        w_emit;
  logic        w_rep;
  logic [24:0] w_limit;
  assign w_limit = (r_state == RPT) ? REPEAT_RATE - 25'd1 : REPEAT_DELAY - 25'd1;
  // IDLE always emits a fresh press; elsewhere a new code or an expired timer does
  always_comb begin
    w_emit = 1'b0;
    w_rep  = 1'b0;
    if (held_key != 8'h00) begin
      if (r_state == IDLE || held_key != r_last) w_emit = 1'b1;
      else if (REPEAT_EN && r_timer == w_limit) begin
        w_emit = 1'b1;
        w_rep  = 1'b1;
      end
    end
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_cand     <= 8'h00;
      r_cnt      <= 16'd0;
      r_last     <= 8'h00;
      r_timer    <= 25'd0;
      r_state    <= IDLE;
      held_key   <= 8'h00;
      key_valid  <= 1'b0;
      key_code   <= 8'h00;
      key_repeat <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (raw_keycode != r_cand) begin
        r_cand <= raw_keycode;
        r_cnt  <= 16'd0;
      end else if (r_cnt == DEBOUNCE_CYC - 16'd1) held_key <= r_cand;
      else r_cnt <= r_cnt + 16'd1;
      if (held_key == 8'h00) begin
        r_state <= IDLE;
        r_timer <= 25'd0;
      end else if (w_emit) begin
        r_state <= w_rep ? RPT : DELAY;
        r_timer <= 25'd0;
        r_last  <= held_key;
      end else if (REPEAT_EN) r_timer <= r_timer + 25'd1;
      if (w_emit && (!key_valid || key_ready)) begin
        key_valid  <= 1'b1;
        key_code   <= held_key;
        key_repeat <= w_rep;
      end else if (w_emit) overrun <= 1'b1;
      else if (key_ready) key_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_keycode_event_gen.sv
// tb_keycode_event_gen: directed and randomized checks of two configurations (repeat on/off)
// against a run-length / key-age event model.
module tb_keycode_event_gen;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RR = 8;
  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       key_ready = 1'b1;
  logic [7:0] raw_keycode = 8'h00;
  logic       v1, r1, o1, v0, r0, o0;
  logic [7:0] c1, h1, c0, h0;
  int vec = 0;
  int miss = 0;
  typedef struct {
    logic [7:0] prev;
    int         run;
    logic [7:0] held;
    logic [7:0] key;
    int         age;
    logic       valid;
    logic [7:0] code;
    logic       rep;
    logic       ovr;
  } mdl_t;
  mdl_t m1, m0;
  always #5 Clk = ~Clk;
  keycode_event_gen #(.DEBOUNCE_CYC(16'd4), .REPEAT_DELAY(25'd20), .REPEAT_RATE(25'd8), .REPEAT_EN(1'b1)) dut (
    .Clk(Clk), .Reset(Reset), .raw_keycode(raw_keycode), .key_ready(key_ready),
    .key_valid(v1), .key_code(c1), .key_repeat(r1), .held_key(h1), .overrun(o1));
  keycode_event_gen #(.DEBOUNCE_CYC(16'd4), .REPEAT_DELAY(25'd20), .REPEAT_RATE(25'd8), .REPEAT_EN(1'b0)) dut0 (
    .Clk(Clk), .Reset(Reset), .raw_keycode(raw_keycode), .key_ready(key_ready),
    .key_valid(v0), .key_code(c0), .key_repeat(r0), .held_key(h0), .overrun(o0));
  // held follows a raw code once it has been sampled DB+1 times in a row;
  // events fire at key age 0 and, with repeat, at ages RD, RD+RR, RD+2RR, ...
  function automatic mdl_t step(input mdl_t m, input logic en, input logic rst, input logic [7:0] raw, input logic rdy);
    mdl_t n;
    logic em, er;
    n = m;
    em = 1'b0;
    er = 1'b0;
    if (rst) begin
      n = '{default: 0};
      n.run = 1;
      return n;
    end
    if (m.held == 8'h00) n.key = 8'h00;
    else if (m.held != m.key) begin
      em = 1'b1;
      n.key = m.held;
      n.age = 0;
    end else begin
      n.age = m.age + 1;
      if (en && n.age >= RD && (n.age - RD) % RR == 0) begin
        em = 1'b1;
        er = 1'b1;
      end
    end
    if (em && (!m.valid || rdy)) begin
      n.valid = 1'b1;
      n.code = m.held;
      n.rep = er;
    end else if (em) n.ovr = 1'b1;
    else if (m.valid && rdy) n.valid = 1'b0;
    if (raw != m.prev) begin
      n.prev = raw;
      n.run = 1;
    end else begin
      n.run = (m.run > DB) ? m.run : m.run + 1;
      if (n.run > DB) n.held = raw;
    end
    return n;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  task automatic cmp(input string tag, input mdl_t m, input logic v, input logic [7:0] c, input logic r, input logic [7:0] h, input logic o);
    chk({tag, "_valid"}, {31'd0, v}, {31'd0, m.valid});
    chk({tag, "_held"}, {24'd0, h}, {24'd0, m.held});
    chk({tag, "_overrun"}, {31'd0, o}, {31'd0, m.ovr});
    if (m.valid) begin
      chk({tag, "_code"}, {24'd0, c}, {24'd0, m.code});
      chk({tag, "_repeat"}, {31'd0, r}, {31'd0, m.rep});
    end
  endtask
  task automatic tick(input logic rst, input logic [7:0] raw, input logic rdy);
    Reset = rst;
    raw_keycode = raw;
    key_ready = rdy;
    @(posedge Clk);
    m1 = step(m1, 1'b1, rst, raw, rdy);
    m0 = step(m0, 1'b0, rst, raw, rdy);
    @(negedge Clk);
    cmp("en", m1, v1, c1, r1, h1, o1);
    cmp("noen", m0, v0, c0, r0, h0, o0);
  endtask
  logic [7:0] codes [4];
  logic [7:0] c;
  logic       any;
  logic       e;
  int         d, rmode, cnt;
  initial begin
    codes = '{8'h00, 8'h1A, 8'h04, 8'h07};
    tick(1'b1, 8'h00, 1'b1);
    tick(1'b1, 8'h00, 1'b1);
    chk("rst_valid", {31'd0, v1}, 32'd0);
    chk("rst_code", {24'd0, c1}, 32'd0);
    chk("rst_repeat", {31'd0, r1}, 32'd0);
    chk("rst_held", {24'd0, h1}, 32'd0);
    chk("rst_overrun", {31'd0, o1}, 32'd0);
    any = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 8'h1A, 1'b1);
      any = any | v1 | (h1 != 8'h00);
    end
    for (int k = 0; k < 10; k++) begin
      tick(1'b0, 8'h00, 1'b1);
      any = any | v1 | (h1 != 8'h00);
    end
    chk("glitch_ignored", {31'd0, any}, 32'd0);
    for (int k = 0; k < 60; k++) begin
      tick(1'b0, 8'h1A, 1'b1);
      e = (k == 5) || (k >= 25 && (k - 25) % 8 == 0);
      chk("hold_valid", {31'd0, v1}, {31'd0, e});
      chk("hold_valid_norpt", {31'd0, v0}, {31'd0, k == 5});
      if (e) begin
        chk("hold_code", {24'd0, c1}, 32'h1A);
        chk("hold_repeat", {31'd0, r1}, {31'd0, k != 5});
      end
    end
    for (int k = 0; k < 6; k++) tick(1'b0, 8'h00, 1'b1);
    chk("release_held", {24'd0, h1}, 32'd0);
    for (int k = 0; k < 10; k++) tick(1'b0, 8'h04, 1'b0);
    for (int k = 0; k < 8; k++) tick(1'b0, 8'h07, 1'b0);
    chk("ovr_valid", {31'd0, v1}, 32'd1);
    chk("ovr_code", {24'd0, c1}, 32'h04);
    chk("ovr_flag", {31'd0, o1}, 32'd1);
    tick(1'b0, 8'h07, 1'b1);
    chk("ovr_drained", {31'd0, v1}, 32'd0);
    for (int k = 0; k < 3; k++) tick(1'b0, 8'h07, 1'b1);
    chk("ovr_stays_idle", {31'd0, v1}, 32'd0);
    tick(1'b1, 8'h00, 1'b1);
    for (int k = 0; k < 10; k++) tick(1'b0, 8'h04, 1'b1);
    for (int k = 0; k < 30; k++) begin
      tick(1'b0, 8'h07, 1'b1);
      chk("change_valid", {31'd0, v1}, {31'd0, k == 5 || k == 25});
      if (k == 5 || k == 25) begin
        chk("change_code", {24'd0, c1}, 32'h07);
        chk("change_repeat", {31'd0, r1}, {31'd0, k == 25});
      end
    end
    for (int k = 0; k < 30; k++) tick(1'b0, 8'h1A, 1'b0);
    chk("pre_reset_pending", {31'd0, v1}, 32'd1);
    tick(1'b1, 8'h1A, 1'b0);
    chk("midrst_valid", {31'd0, v1}, 32'd0);
    chk("midrst_code", {24'd0, c1}, 32'd0);
    chk("midrst_repeat", {31'd0, r1}, 32'd0);
    chk("midrst_held", {24'd0, h1}, 32'd0);
    chk("midrst_overrun", {31'd0, o1}, 32'd0);
    for (int k = 0; k < 10; k++) begin
      tick(1'b0, 8'h1A, 1'b1);
      chk("post_rst_valid", {31'd0, v1}, {31'd0, k == 5});
      if (k == 5) chk("post_rst_repeat", {31'd0, r1}, 32'd0);
    end
    tick(1'b1, 8'h00, 1'b1);
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      tick(1'b0, 8'h28, 1'b1);
      if (v0) begin
        cnt++;
        chk("norpt_code", {24'd0, c0}, 32'h28);
        chk("norpt_repeat", {31'd0, r0}, 32'd0);
      end
    end
    chk("norpt_events", cnt, 32'd1);
    for (int s = 0; s < 160; s++) begin
      c = codes[$urandom_range(0, 3)];
      d = $urandom_range(1, 40);
      rmode = $urandom_range(0, 3);
      for (int i = 0; i < d; i++)
        tick($urandom_range(0, 499) == 0, c, rmode == 0 ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
